// File: rtl/led_pattern_seq_pkg.sv
// Shared constants and helpers for the LED pattern sequencer.
package led_seq_pkg;

    localparam logic [1:0] MODE_ROT_L  = 2'd0;
    localparam logic [1:0] MODE_ROT_R  = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_FILL   = 2'd3;

    // LEFT moves the lit bit toward the MSB, RIGHT toward the LSB.
    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    // Prescaler terminal count for speed select 'sel'. Computed wide so the
    // caller can truncate to its own counter width.
    function automatic logic [63:0] lim(input int sel, input int log2_base);
        return (64'd1 << (log2_base + sel)) - 64'd1;
    endfunction

endpackage

// File: rtl/led_pattern_seq_tick_gen.sv
// Prescaler: free-running up-counter with a selectable terminal count, plus
// the single-step bypass used while the sequencer is paused.
module led_tick_gen
    import led_seq_pkg::*;
#(
    parameter int NB_SEL    = 2,
    parameter int NB_COUNT  = 32,
    parameter int LOG2_BASE = 22
) (
    input  logic              clock,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic              i_step,
    input  logic [NB_SEL-1:0] i_speed,
    output logic              o_step
);

    logic [NB_COUNT-1:0] count;
    logic [NB_COUNT-1:0] limit;
    logic                at_limit;

    // Limit follows i_speed live; '>=' means a lowered limit fires right away.
    always_comb begin
        limit = NB_COUNT'(lim(int'(i_speed), LOG2_BASE));
    end

    assign at_limit = (count >= limit);

    // While paused the counter holds and i_step alone produces a step.
    assign o_step = i_enable ? at_limit : i_step;

    // Counter advances only when enabled and clears on terminal count.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            count <= '0;
        end else if (i_enable) begin
            if (at_limit) begin
                count <= '0;
            end else begin
                count <= count + NB_COUNT'(1);
            end
        end
    end

endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: holds the pattern/mode/direction state, advances it
// on each prescaler step and routes the pattern to the selected colour bank.
module led_pattern_seq
    import led_seq_pkg::*;
#(
    parameter int N_LEDS    = 4,
    parameter int NB_SEL    = 2,
    parameter int NB_COUNT  = 32,
    parameter int LOG2_BASE = 22
) (
    input  logic              clock,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic              i_step,
    input  logic [1:0]        i_mode,
    input  logic [NB_SEL-1:0] i_speed,
    input  logic              i_color,
    output logic [N_LEDS-1:0] o_led,
    output logic [N_LEDS-1:0] o_led_b,
    output logic [N_LEDS-1:0] o_led_g,
    output logic              o_tick
);

    localparam logic [N_LEDS-1:0] PAT_INIT = {{(N_LEDS-1){1'b0}}, 1'b1};

    logic              step;
    logic [N_LEDS-1:0] pattern;
    logic [1:0]        mode_q;
    dir_e              dir;

    led_tick_gen #(
        .NB_SEL    (NB_SEL),
        .NB_COUNT  (NB_COUNT),
        .LOG2_BASE (LOG2_BASE)
    ) u_tick_gen (
        .clock    (clock),
        .i_reset  (i_reset),
        .i_enable (i_enable),
        .i_step   (i_step),
        .i_speed  (i_speed),
        .o_step   (step)
    );

    // Pattern state machine: a step either latches a new mode (restarting
    // from the single-LED pattern) or advances the current mode by one.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            pattern <= PAT_INIT;
            dir     <= DIR_LEFT;
            mode_q  <= MODE_ROT_L;
            o_tick  <= 1'b0;
        end else begin
            o_tick <= step;
            if (step) begin
                if (i_mode != mode_q) begin
                    mode_q  <= i_mode;
                    pattern <= PAT_INIT;
                    dir     <= DIR_LEFT;
                end else begin
                    case (mode_q)
                        MODE_ROT_L: pattern <= {pattern[N_LEDS-2:0], pattern[N_LEDS-1]};
                        MODE_ROT_R: pattern <= {pattern[0], pattern[N_LEDS-1:1]};
                        MODE_BOUNCE: begin
                            // Reverse at the end bit and move away in the same step.
                            if (dir == DIR_LEFT) begin
                                if (pattern[N_LEDS-1]) begin
                                    dir     <= DIR_RIGHT;
                                    pattern <= pattern >> 1;
                                end else begin
                                    pattern <= pattern << 1;
                                end
                            end else begin
                                if (pattern[0]) begin
                                    dir     <= DIR_LEFT;
                                    pattern <= pattern << 1;
                                end else begin
                                    pattern <= pattern >> 1;
                                end
                            end
                        end
                        default: begin
                            if (&pattern) begin
                                pattern <= PAT_INIT;
                            end else begin
                                pattern <= {pattern[N_LEDS-2:0], 1'b1};
                            end
                        end
                    endcase
                end
            end
        end
    end

    assign o_led = pattern;

    // Colour bank select is combinational so a toggle shows up immediately.
    always_comb begin
        o_led_b = i_color ? '0 : pattern;
        o_led_g = i_color ? pattern : '0;
    end

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed testbench for led_pattern_seq with small parameters
// (limits 3, 7, 15, 31 for speeds 0..3).
module tb_led_pattern_seq;

    logic       clock = 1'b0;
    logic       i_reset;
    logic       i_enable;
    logic       i_step;
    logic [1:0] i_mode;
    logic [1:0] i_speed;
    logic       i_color;
    logic [3:0] o_led;
    logic [3:0] o_led_b;
    logic [3:0] o_led_g;
    logic       o_tick;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    led_pattern_seq #(
        .N_LEDS    (4),
        .NB_SEL    (2),
        .NB_COUNT  (8),
        .LOG2_BASE (2)
    ) dut (
        .clock    (clock),
        .i_reset  (i_reset),
        .i_enable (i_enable),
        .i_step   (i_step),
        .i_mode   (i_mode),
        .i_speed  (i_speed),
        .i_color  (i_color),
        .o_led    (o_led),
        .o_led_b  (o_led_b),
        .o_led_g  (o_led_g),
        .o_tick   (o_tick)
    );

    // Advance one clock and settle just after the edge.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        i_reset  = 1'b1;
        i_enable = 1'b0;
        i_step   = 1'b0;
        i_mode   = 2'd0;
        i_speed  = 2'd0;
        i_color  = 1'b0;
        #3 i_reset = 1'b0;
        cyc();
        cyc();
        checks++;
        if (o_led !== 4'b0001 || o_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: led=%b tick=%b, expected led=0001 tick=0", o_led, o_tick);
        end
        checks++;
        if (o_led_b !== 4'b0001 || o_led_g !== 4'b0000) begin
            errors++;
            $display("FAIL reset_banks: b=%b g=%b, expected b=0001 g=0000", o_led_b, o_led_g);
        end
        i_reset = 1'b1;
    endtask

    task automatic test_reset_mid();
        i_enable = 1'b1;
        for (int c = 0; c < 4; c++) cyc();
        checks++;
        if (o_led !== 4'b0010 || o_tick !== 1'b1) begin
            errors++;
            $display("FAIL warmup_step: led=%b tick=%b, expected led=0010 tick=1", o_led, o_tick);
        end
        i_reset = 1'b0;
        #1;
        checks++;
        if (o_led !== 4'b0001 || o_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: led=%b tick=%b, expected led=0001 tick=0", o_led, o_tick);
        end
        cyc();
        cyc();
        i_reset = 1'b1;
    endtask

    task automatic test_rot_l();
        logic [3:0] exp_seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [3:0] prev = 4'b0001;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 3; c++) begin
                cyc();
                checks++;
                if (o_led !== prev || o_tick !== 1'b0) begin
                    errors++;
                    $display("FAIL rot_l_idle s%0d c%0d: led=%b tick=%b, expected led=%b tick=0", s, c, o_led, o_tick, prev);
                end
            end
            cyc();
            checks++;
            if (o_led !== exp_seq[s] || o_tick !== 1'b1) begin
                errors++;
                $display("FAIL rot_l_step %0d: led=%b tick=%b, expected led=%b tick=1", s, o_led, o_tick, exp_seq[s]);
            end
            prev = exp_seq[s];
        end
    endtask

    task automatic test_bounce();
        logic [3:0] exp_seq [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                    4'b0100, 4'b0010, 4'b0001, 4'b0010};
        logic [3:0] prev = 4'b0001;
        i_mode = 2'd2;
        for (int s = 0; s < 8; s++) begin
            for (int c = 0; c < 3; c++) begin
                cyc();
                checks++;
                if (o_led !== prev || o_tick !== 1'b0) begin
                    errors++;
                    $display("FAIL bounce_idle s%0d c%0d: led=%b tick=%b, expected led=%b tick=0", s, c, o_led, o_tick, prev);
                end
            end
            cyc();
            checks++;
            if (o_led !== exp_seq[s] || o_tick !== 1'b1) begin
                errors++;
                $display("FAIL bounce_step %0d: led=%b tick=%b, expected led=%b tick=1", s, o_led, o_tick, exp_seq[s]);
            end
            prev = exp_seq[s];
        end
    endtask

    task automatic test_fill_then_rot_r();
        logic [3:0] exp_seq [10] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0001,
                                     4'b0011, 4'b0111, 4'b0001, 4'b1000, 4'b0100};
        logic [3:0] prev = 4'b0010;
        i_mode = 2'd3;
        for (int s = 0; s < 10; s++) begin
            if (s == 7) i_mode = 2'd1;
            for (int c = 0; c < 3; c++) begin
                cyc();
                checks++;
                if (o_led !== prev || o_tick !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_idle s%0d c%0d: led=%b tick=%b, expected led=%b tick=0", s, c, o_led, o_tick, prev);
                end
            end
            cyc();
            checks++;
            if (o_led !== exp_seq[s] || o_tick !== 1'b1) begin
                errors++;
                $display("FAIL fill_step %0d: led=%b tick=%b, expected led=%b tick=1", s, o_led, o_tick, exp_seq[s]);
            end
            prev = exp_seq[s];
        end
    endtask

    task automatic test_speed_change();
        logic [3:0] exp_seq [2] = '{4'b0001, 4'b1000};
        logic [3:0] prev = 4'b0100;
        i_speed = 2'd3;
        for (int c = 0; c < 10; c++) begin
            cyc();
            checks++;
            if (o_led !== 4'b0100 || o_tick !== 1'b0) begin
                errors++;
                $display("FAIL slow_idle c%0d: led=%b tick=%b, expected led=0100 tick=0", c, o_led, o_tick);
            end
        end
        i_speed = 2'd0;
        cyc();
        checks++;
        if (o_led !== 4'b0010 || o_tick !== 1'b1) begin
            errors++;
            $display("FAIL speed_drop_step: led=%b tick=%b, expected led=0010 tick=1", o_led, o_tick);
        end
        prev = 4'b0010;
        for (int s = 0; s < 2; s++) begin
            for (int c = 0; c < 3; c++) begin
                cyc();
                checks++;
                if (o_led !== prev || o_tick !== 1'b0) begin
                    errors++;
                    $display("FAIL fast_idle s%0d c%0d: led=%b tick=%b, expected led=%b tick=0", s, c, o_led, o_tick, prev);
                end
            end
            cyc();
            checks++;
            if (o_led !== exp_seq[s] || o_tick !== 1'b1) begin
                errors++;
                $display("FAIL fast_step %0d: led=%b tick=%b, expected led=%b tick=1", s, o_led, o_tick, exp_seq[s]);
            end
            prev = exp_seq[s];
        end
    endtask

    task automatic test_pause_step();
        logic [3:0] exp_seq [3] = '{4'b0100, 4'b0010, 4'b0001};
        i_enable = 1'b0;
        for (int c = 0; c < 50; c++) begin
            cyc();
            checks++;
            if (o_led !== 4'b1000 || o_tick !== 1'b0) begin
                errors++;
                $display("FAIL paused_hold c%0d: led=%b tick=%b, expected led=1000 tick=0", c, o_led, o_tick);
            end
        end
        for (int p = 0; p < 3; p++) begin
            i_step = 1'b1;
            cyc();
            i_step = 1'b0;
            checks++;
            if (o_led !== exp_seq[p] || o_tick !== 1'b1) begin
                errors++;
                $display("FAIL single_step %0d: led=%b tick=%b, expected led=%b tick=1", p, o_led, o_tick, exp_seq[p]);
            end
            cyc();
            checks++;
            if (o_led !== exp_seq[p] || o_tick !== 1'b0) begin
                errors++;
                $display("FAIL single_step_after %0d: led=%b tick=%b, expected led=%b tick=0", p, o_led, o_tick, exp_seq[p]);
            end
            cyc();
        end
        // Counter was frozen at 0, and i_step is ignored while enabled.
        i_enable = 1'b1;
        i_step   = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cyc();
            checks++;
            if (o_led !== 4'b0001 || o_tick !== 1'b0) begin
                errors++;
                $display("FAIL step_ignored c%0d: led=%b tick=%b, expected led=0001 tick=0", c, o_led, o_tick);
            end
        end
        cyc();
        checks++;
        if (o_led !== 4'b1000 || o_tick !== 1'b1) begin
            errors++;
            $display("FAIL resume_step: led=%b tick=%b, expected led=1000 tick=1", o_led, o_tick);
        end
        i_step   = 1'b0;
        i_enable = 1'b0;
    endtask

    task automatic test_color();
        i_color = 1'b1;
        #1;
        checks++;
        if (o_led_b !== 4'b0000 || o_led_g !== 4'b1000 || o_led !== 4'b1000) begin
            errors++;
            $display("FAIL color_green: led=%b b=%b g=%b, expected led=1000 b=0000 g=1000", o_led, o_led_b, o_led_g);
        end
        i_color = 1'b0;
        #1;
        checks++;
        if (o_led_b !== 4'b1000 || o_led_g !== 4'b0000 || o_led !== 4'b1000) begin
            errors++;
            $display("FAIL color_blue: led=%b b=%b g=%b, expected led=1000 b=1000 g=0000", o_led, o_led_b, o_led_g);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_rot_l();
        test_bounce();
        test_fill_then_rot_r();
        test_speed_change();
        test_pause_step();
        test_color();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
